// File: rtl/im2col_sched.sv
// Patch-origin scheduler: latches an image/kernel/stride job, validates it and walks
// every kernel window in raster order over a valid/ready port. Optional macro: IM2COL_SCHED_STALL_CNT_EN.
module im2col_sched #(
  parameter int H  = 512,
  parameter int W  = 512,
  parameter int K  = 16,
  parameter int HB = $clog2(H+1),
  parameter int WB = $clog2(W+1),
  parameter int KB = $clog2(K+1),
  parameter int IB = $clog2(H*W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [HB-1:0] cfg_im_h,
  input  logic [WB-1:0] cfg_im_w,
  input  logic [KB-1:0] cfg_k_h,
  input  logic [KB-1:0] cfg_k_w,
  input  logic [KB-1:0] cfg_stride,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          patch_valid,
  input  logic          patch_ready,
  output logic [HB-1:0] patch_row,
  output logic [WB-1:0] patch_col,
  output logic [IB-1:0] patch_idx,
  output logic          patch_last
`ifdef IM2COL_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  // One spare bit over the wider axis so origin+stride+kernel never wraps.
  localparam int AB = ((HB > WB) ? HB : WB) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [HB-1:0] im_h_q, im_h_d;
  logic [WB-1:0] im_w_q, im_w_d;
  logic [KB-1:0] k_h_q, k_h_d, k_w_q, k_w_d, stride_q, stride_d;
  logic [HB-1:0] row_q, row_d;
  logic [WB-1:0] col_q, col_d;
  logic [IB-1:0] idx_q, idx_d;
  logic          cfg_err_q, cfg_err_d;

  logic [AB-1:0] col_end, row_end;
  logic          col_fits, row_fits, cfg_bad, handshake;

  always_comb begin
    col_end  = AB'(col_q) + AB'(stride_q) + AB'(k_w_q);
    row_end  = AB'(row_q) + AB'(stride_q) + AB'(k_h_q);
    col_fits = (col_end <= AB'(im_w_q));
    row_fits = (row_end <= AB'(im_h_q));
    cfg_bad  = (cfg_k_h == '0) || (cfg_k_w == '0) || (cfg_stride == '0) ||
               (AB'(cfg_k_h) > AB'(cfg_im_h)) || (AB'(cfg_k_w) > AB'(cfg_im_w));
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign patch_valid = (state_q == S_RUN);
  assign patch_last  = !col_fits && !row_fits;
  assign patch_row   = row_q;
  assign patch_col   = col_q;
  assign patch_idx   = idx_q;
  assign cfg_err     = cfg_err_q;
  assign handshake   = patch_valid && patch_ready;

  always_comb begin
    state_d   = state_q;
    im_h_d    = im_h_q;
    im_w_d    = im_w_q;
    k_h_d     = k_h_q;
    k_w_d     = k_w_q;
    stride_d  = stride_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          im_h_d    = cfg_im_h;
          im_w_d    = cfg_im_w;
          k_h_d     = cfg_k_h;
          k_w_d     = cfg_k_w;
          stride_d  = cfg_stride;
          row_d     = '0;
          col_d     = '0;
          idx_d     = '0;
          cfg_err_d = cfg_bad;
          state_d   = cfg_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (handshake) begin
          idx_d = idx_q + IB'(1);
          if (patch_last) begin
            state_d = S_DONE;
          end else if (col_fits) begin
            col_d = col_q + WB'(stride_q);
          end else begin
            col_d = '0;
            row_d = row_q + HB'(stride_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      im_h_q    <= '0;
      im_w_q    <= '0;
      k_h_q     <= '0;
      k_w_q     <= '0;
      stride_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      im_h_q    <= im_h_d;
      im_w_q    <= im_w_d;
      k_h_q     <= k_h_d;
      k_w_q     <= k_w_d;
      stride_q  <= stride_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef IM2COL_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of back-pressured cycles; restarts with each accepted job.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (patch_valid && !patch_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/im2col_sched.md
# im2col_sched

Patch-origin scheduler for the GEMM im2col path. On a start pulse it latches an image/kernel/stride configuration, validates it, and walks every valid kernel window in raster order (row-major, step = stride). It emits one window origin per valid/ready handshake to the downstream patch-extraction datapath, then pulses done. It replaces free-running row/column counters with a back-pressure-aware, error-checked sequencer.

## Interface
Parameters:
- H, 512, maximum image height
- W, 512, maximum image width
- K, 16, maximum kernel edge and stride
- HB, $clog2(H+1), width of height/row fields
- WB, $clog2(W+1), width of width/column fields
- KB, $clog2(K+1), width of kernel/stride fields
- IB, $clog2(H*W), width of patch index

Ports:
- Clock and reset (already decided): reset is synchronous and active-high; the clock is clk.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- cfg_im_h  in  HB  image height
- cfg_im_w  in  WB  image width
- cfg_k_h  in  KB  kernel height
- cfg_k_w  in  KB  kernel width
- cfg_stride  in  KB  stride, applied to both axes
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at end of job
- cfg_err  out  1  sticky error flag for the last job, cleared by the next accepted start
- patch_valid  out  1  origin available
- patch_ready  in  1  downstream accepts origin
- patch_row  out  HB  window top row
- patch_col  out  WB  window left column
- patch_idx  out  IB  sequential window number, 0-based
- patch_last  out  1  current origin is the final window

## Operation
- Three states: IDLE, RUN and DONE.
- **IDLE.** When start is high, the block latches all cfg_* inputs and clears cfg_err.
  - Error check: the configuration is invalid if any of the following holds: k_h==0, k_w==0, stride==0, k_h>im_h, k_w>im_w.
  - Invalid configuration: set cfg_err=1 and go to DONE.
  - Valid configuration: row=0, col=0, idx=0, and go to RUN.
- **RUN.** patch_valid=1. On a handshake (patch_valid & patch_ready):
  - If patch_last is high, go to DONE.
  - Else, if col+stride+k_w <= im_w: col += stride.
  - Else: col = 0 and row += stride.
  - idx increments on every handshake.
- **patch_last** is combinational from the registered state: (col+stride+k_w > im_w) && (row+stride+k_h > im_h).
- **Arithmetic width.** All of these sums are evaluated at max(HB,WB)+1 bits, so no wrap occurs at maximum values.
- **DONE.** done=1 for exactly one cycle, then the block returns to IDLE.
- **Ignored inputs.** start is ignored outside IDLE. cfg_* changes after the latch cycle have no effect.
- **Outputs** patch_row, patch_col and patch_idx hold their values while patch_valid is high and patch_ready is low.
- **Total windows** per job = ((im_h-k_h)/stride+1) × ((im_w-k_w)/stride+1). A window never extends beyond the image; no padding is applied.

## Timing
- **Reset values.** State=IDLE. busy, done, cfg_err, patch_valid and patch_last are 0. patch_row, patch_col and patch_idx are 0.
- **Reset mid-job.** Reset takes effect the next edge regardless of state; no done pulse is generated.
- **Start latency.** start at edge N gives patch_valid=1 and busy=1 after edge N+1, with origin (0,0) presented.
- **Throughput.** One origin per cycle when patch_ready is held high.
- **Job end.** The last handshake at edge M gives done=1 and patch_valid=0 after edge M+1. busy falls after edge M+2.
- **Error path.** start at edge N gives done=1 and cfg_err=1 after edge N+1, with no patch_valid.
- **Re-start.** A start in the same cycle as done is ignored; the earliest accepted start is the cycle after done.

## Configuration
- **Macro:** IM2COL_SCHED_STALL_CNT_EN.
- **When defined:** adds output stall_cnt, 32 bits.
  - Counts cycles with patch_valid & !patch_ready.
  - Saturates at 2^32-1.
  - Cleared on an accepted start and on reset.
  - Holds its value after done.
- **When undefined:** the port and counter do not exist; all other behaviour is identical.

## Test plan
- **Basic raster walk.** 8×8 image, k=3×3, stride 1, ready held high.
  - Required: 36 consecutive origins.
  - First origin is (0,0) with idx 0; (0,5) is followed by (1,0).
  - Last origin is (5,5) with idx 35 and patch_last=1.
  - done pulses one cycle later.
- **Stride 2.** 8×8 image, k=3×3, stride 2.
  - Required: 9 origins, with rows and columns drawn from {0,2,4}.
  - Last origin is (4,4) with idx 8.
- **Back-pressure.** Same as the basic case, with patch_ready toggling at random and held low for 5 cycles on the origin at idx 10.
  - Required: the origin stays at (1,4) and idx 10 throughout the hold.
  - No origin is skipped or repeated.
  - stall_cnt equals the number of low-ready cycles when the macro is defined.
- **Config error.** k_w=0, or k_h=9 with im_h=8.
  - Required: done and cfg_err both high 1 cycle after start; patch_valid is never asserted.
  - cfg_err clears on the next valid start.
- **Exact fit.** im=4×4, k=4×4.
  - Required: a single origin (0,0) with patch_last=1, then done.
- **Reset mid-job and ignored start.** Assert reset at idx 7 of the basic case, then start a new job.
  - Required: all outputs are at their reset values the cycle after reset, with no done pulse.
  - The new job starts from (0,0) with idx 0.
  - A start pulsed during RUN is ignored.
